// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output chain.
// sat16 clamps a sign-extended, gain-shifted FIR sample into the 16-bit range.
package fir_pkg;

  localparam int FIR_OUT_W = 24;
  localparam int SAMPLE_W  = 16;
  localparam int WIDE_W    = FIR_OUT_W + 7;

  typedef logic signed [FIR_OUT_W-1:0] fir_out_t;
  typedef logic signed [SAMPLE_W-1:0]  sample_t;
  typedef logic signed [WIDE_W-1:0]    wide_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  function automatic sample_t sat16(input wide_t x);
    sample_t r;
    if (x > wide_t'(SAT_MAX)) begin
      r = SAT_MAX;
    end else if (x < wide_t'(SAT_MIN)) begin
      r = SAT_MIN;
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO on a register array; a push while full is accepted only
// together with a pop, so a full FIFO streams at one word per cycle.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (level_r == {LW{1'b0}});
  assign full      = (level_r == LW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage array; contents need no reset because reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/fir_dec_fifo.sv
// Post-FIR stage: drops fill samples, decimates, applies gain with saturation,
// and buffers results for a valid/ready consumer.
module fir_dec_fifo
  import fir_pkg::*;
#(
  parameter  int DECIM = 4,
  parameter  int SKIP  = 3,
  parameter  int SHIFT = 0,
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [FIR_OUT_W-1:0] din,
  input  logic                       din_vld,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [LW-1:0]              level,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  logic [7:0]    skip_cnt_r;
  logic [7:0]    dec_cnt_r;
  logic          ovf_r;
  logic          kept_s;
  logic          pop_s;
  logic          drop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  wide_t         wide_s;
  sample_t       sat_s;
  sample_t       head_s;

  assign kept_s = din_vld && (skip_cnt_r == 8'd0) && (dec_cnt_r == 8'd0);
  assign pop_s  = !fifo_empty_s && dout_rdy;
  assign drop_s = kept_s && fifo_full_s && !pop_s;
  assign wide_s = wide_t'(din) <<< SHIFT;
  assign sat_s  = sat16(wide_s);

  // Fill-sample skipping, then modulo-DECIM phase counting of accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt_r <= 8'(SKIP);
      dec_cnt_r  <= 8'd0;
    end else if (din_vld) begin
      if (skip_cnt_r != 8'd0) begin
        skip_cnt_r <= skip_cnt_r - 8'd1;
      end else if (dec_cnt_r == 8'(DECIM - 1)) begin
        dec_cnt_r <= 8'd0;
      end else begin
        dec_cnt_r <= dec_cnt_r + 8'd1;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (kept_s),
    .pop   (pop_s),
    .wdata (sat_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level)
  );

  // Output presentation: head is forced to zero while nothing is buffered.
  always_comb begin
    dout     = '0;
    dout_vld = 1'b0;
    if (fifo_empty_s) begin
      dout     = '0;
      dout_vld = 1'b0;
    end else begin
      dout     = head_s;
      dout_vld = 1'b1;
    end
  end

  assign ovf = ovf_r;

endmodule

// File: tb/tb_fir_dec_fifo.sv
// Bench for fir_dec_fifo: two configurations checked every cycle against a
// queue-based model, plus hand-computed expectations for the directed cases.
module tb_fir_dec_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic signed [23:0] din_a = '0, din_b = '0;
  logic vld_a = 1'b0, vld_b = 1'b0;
  logic rdy_a = 1'b0, rdy_b = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic signed [15:0] dout_a, dout_b;
  logic dv_a, dv_b, ovf_a, ovf_b;
  logic [3:0] lvl_a, lvl_b;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir_dec_fifo #(.DECIM(4), .SKIP(3), .SHIFT(0), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_vld(vld_a),
    .dout(dout_a), .dout_vld(dv_a), .dout_rdy(rdy_a),
    .level(lvl_a), .ovf(ovf_a), .ovf_clr(clr_a));

  fir_dec_fifo #(.DECIM(1), .SKIP(0), .SHIFT(2), .DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_vld(vld_b),
    .dout(dout_b), .dout_vld(dv_b), .dout_rdy(rdy_b),
    .level(lvl_b), .ovf(ovf_b), .ovf_clr(clr_b));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int q_a[$], q_b[$];
  int skip_a, skip_b, cnt_a, cnt_b;
  bit movf_a, movf_b;

  function automatic int gain_sat(input int d, input int sh);
    longint w;
    w = longint'(d) * (longint'(1) << sh);
    if (w > 32767) return 32767;
    if (w < -32768) return -32768;
    return int'(w);
  endfunction

  task automatic model_reset();
    q_a.delete(); q_b.delete();
    skip_a = 3; skip_b = 0; cnt_a = 0; cnt_b = 0;
    movf_a = 1'b0; movf_b = 1'b0;
  endtask

  initial begin
    bit pop, keep, full;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        // config A: DECIM 4, SKIP 3, SHIFT 0, DEPTH 8
        pop = (q_a.size() > 0) && rdy_a;
        full = (q_a.size() == 8);
        keep = 1'b0;
        if (vld_a) begin
          if (skip_a > 0) skip_a--;
          else begin keep = (cnt_a % 4 == 0); cnt_a++; end
        end
        if (pop) void'(q_a.pop_front());
        if (keep && full && !pop) movf_a = 1'b1;
        else begin
          if (keep) q_a.push_back(gain_sat(int'(din_a), 0));
          if (clr_a) movf_a = 1'b0;
        end
        // config B: DECIM 1, SKIP 0, SHIFT 2, DEPTH 8
        pop = (q_b.size() > 0) && rdy_b;
        full = (q_b.size() == 8);
        keep = 1'b0;
        if (vld_b) begin
          if (skip_b > 0) skip_b--;
          else keep = 1'b1;
        end
        if (pop) void'(q_b.pop_front());
        if (keep && full && !pop) movf_b = 1'b1;
        else begin
          if (keep) q_b.push_back(gain_sat(int'(din_b), 2));
          if (clr_b) movf_b = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("a_dout",  int'(dout_a), (q_a.size() > 0) ? q_a[0] : 0);
        chk("a_vld",   int'(dv_a),   int'(q_a.size() > 0));
        chk("a_level", int'(lvl_a),  q_a.size());
        chk("a_ovf",   int'(ovf_a),  int'(movf_a));
        chk("b_dout",  int'(dout_b), (q_b.size() > 0) ? q_b[0] : 0);
        chk("b_vld",   int'(dv_b),   int'(q_b.size() > 0));
        chk("b_level", int'(lvl_b),  q_b.size());
        chk("b_ovf",   int'(ovf_b),  int'(movf_b));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_vld", int'(dv_a), 0);
    chk("rst_a_dout", int'(dout_a), 0);
    chk("rst_a_level", int'(lvl_a), 0);
    chk("rst_a_ovf", int'(ovf_a), 0);
    rst_n = 1'b1;

    // Ramp through config A: samples 0..2 skipped, then every 4th kept
    vld_a = 1'b1; rdy_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din_a = 24'(i);
      tick();
      chk("ramp_vld", int'(dv_a), int'(i >= 3 && ((i - 3) % 4) == 0));
      if (i >= 3 && ((i - 3) % 4) == 0) chk("ramp_dout", int'(dout_a), i);
    end
    vld_a = 1'b0;
    tick();

    // Gain and saturation on config B
    rdy_b = 1'b1; vld_b = 1'b1;
    din_b = 24'sd10000; tick(); chk("sat_hi", int'(dout_b), 32767);
    din_b = 24'sd8191;  tick(); chk("sat_mid", int'(dout_b), 32764);
    din_b = -24'sd9000; tick(); chk("sat_lo", int'(dout_b), -32768);
    vld_b = 1'b0; tick();
    chk("empty_vld", int'(dv_b), 0);
    chk("empty_dout", int'(dout_b), 0);

    // Overflow: 10 pushes into 8 entries with no consumer
    rdy_b = 1'b0; vld_b = 1'b1;
    for (int j = 1; j <= 10; j++) begin din_b = 24'(j); tick(); end
    vld_b = 1'b0;
    chk("ovf_level", int'(lvl_b), 8);
    chk("ovf_set", int'(ovf_b), 1);
    rdy_b = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      chk("drain_order", int'(dout_b), 4 * j);
      tick();
    end
    chk("drain_level", int'(lvl_b), 0);
    chk("ovf_sticky", int'(ovf_b), 1);
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    chk("ovf_clr", int'(ovf_b), 0);

    // Full FIFO with simultaneous push and pop
    rdy_b = 1'b0; vld_b = 1'b1;
    for (int j = 1; j <= 8; j++) begin din_b = 24'(j); tick(); end
    chk("full_level", int'(lvl_b), 8);
    rdy_b = 1'b1;
    din_b = 24'd9; tick();
    chk("fpp_level", int'(lvl_b), 8);
    chk("fpp_ovf", int'(ovf_b), 0);
    chk("fpp_head", int'(dout_b), 8);
    din_b = 24'd10; tick();
    din_b = 24'd11; tick();
    chk("fpp_level2", int'(lvl_b), 8);
    chk("fpp_head2", int'(dout_b), 16);
    vld_b = 1'b0;
    repeat (8) tick();
    chk("fpp_drained", int'(lvl_b), 0);

    // Consumer stall for 3 cycles mid-stream
    vld_b = 1'b1; rdy_b = 1'b1;
    din_b = 24'd20; tick(); chk("st_head0", int'(dout_b), 80);
    din_b = 24'd21; tick(); chk("st_head1", int'(dout_b), 84);
    rdy_b = 1'b0;
    for (int j = 0; j < 3; j++) begin
      din_b = 24'(22 + j);
      tick();
      chk("st_hold", int'(dout_b), 84);
      chk("st_level", int'(lvl_b), 2 + j);
    end
    vld_b = 1'b0; rdy_b = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("st_drain", int'(dout_b), 84 + 4 * j);
      tick();
    end
    chk("st_empty", int'(dv_b), 0);

    // Reset mid-operation with 5 entries buffered in config A
    vld_a = 1'b1; rdy_a = 1'b0; k = 200;
    for (int c = 0; c < 40 && lvl_a != 4'd5; c++) begin
      din_a = 24'(k); k++; tick();
    end
    chk("rst_pre_level", int'(lvl_a), 5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_level", int'(lvl_a), 0);
    chk("rst_mid_vld", int'(dv_a), 0);
    chk("rst_mid_dout", int'(dout_a), 0);
    tick();
    rst_n = 1'b1; rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din_a = 24'(100 + i);
      tick();
      chk("rst2_vld", int'(dv_a), int'(i == 3 || i == 7));
      if (i == 3 || i == 7) chk("rst2_dout", int'(dout_a), 100 + i);
    end
    vld_a = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
